// File: rtl/hazard_fwd_ctrl.sv
// Hazard/forwarding controller for the 5-stage MIPS pipeline: EX/MEM/WB destination shadows,
// ALU forwarding selects and load-use stall. Macro HAZARD_FWD_EN enables forwarding.
module hazard_fwd_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_reg_dst,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             flush,
    output logic             ex_dest_sel,
    output logic [REG_W-1:0] ex_dest,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             stall,
    output logic             pc_we,
    output logic             ifid_we,
    output logic [CNT_W-1:0] stall_cnt
);

    logic             ex_rw;
    logic             ex_mr;
    logic [REG_W-1:0] ex_rs;
    logic [REG_W-1:0] ex_rt;
    logic             mem_rw;
    logic [REG_W-1:0] mem_dest;
    logic             wb_rw;
    logic [REG_W-1:0] wb_dest;
    logic             capture;
    logic             ex_live;

    assign capture = id_valid & ~stall & ~flush;
    assign ex_live = ex_rw & (ex_dest != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_dest_sel <= 1'b0;
            ex_dest     <= '0;
            ex_rw       <= 1'b0;
            ex_mr       <= 1'b0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            mem_rw      <= 1'b0;
            mem_dest    <= '0;
            wb_rw       <= 1'b0;
            wb_dest     <= '0;
        end else begin
            wb_rw    <= mem_rw;
            wb_dest  <= mem_dest;
            mem_rw   <= ex_rw;
            mem_dest <= ex_dest;
            if (capture) begin
                ex_dest_sel <= id_reg_dst;
                ex_dest     <= id_reg_dst ? id_rd : id_rt;
                ex_rw       <= id_reg_write;
                ex_mr       <= id_mem_read;
                ex_rs       <= id_rs;
                ex_rt       <= id_rt;
            end else begin
                // Stalled, flushed or empty ID slot: EX receives a bubble.
                ex_dest_sel <= 1'b0;
                ex_dest     <= '0;
                ex_rw       <= 1'b0;
                ex_mr       <= 1'b0;
                ex_rs       <= '0;
                ex_rt       <= '0;
            end
        end
    end

`ifdef HAZARD_FWD_EN
    logic mem_live;
    logic wb_live;

    assign mem_live = mem_rw & (mem_dest != '0);
    assign wb_live  = wb_rw & (wb_dest != '0);

    // MEM has the younger result, so it wins over WB when both match.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (mem_live && mem_dest == ex_rs)
            fwd_a = 2'b10;
        else if (wb_live && wb_dest == ex_rs)
            fwd_a = 2'b01;
        if (mem_live && mem_dest == ex_rt)
            fwd_b = 2'b10;
        else if (wb_live && wb_dest == ex_rt)
            fwd_b = 2'b01;
    end

    assign stall = id_valid & ~flush & ex_mr & ex_live &
                   ((ex_dest == id_rs) | (ex_dest == id_rt));
`else
    logic mem_live;
    logic unused_shadow;

    assign mem_live = mem_rw & (mem_dest != '0);
    assign fwd_a    = 2'b00;
    assign fwd_b    = 2'b00;

    // WB needs no check: the register file writes before it reads within a cycle.
    assign stall = id_valid & ~flush &
                   ((ex_live  & ((ex_dest  == id_rs) | (ex_dest  == id_rt))) |
                    (mem_live & ((mem_dest == id_rs) | (mem_dest == id_rt))));

    assign unused_shadow = ^{ex_mr, ex_rs, ex_rt, wb_rw, wb_dest};
`endif

    assign pc_we   = ~stall;
    assign ifid_we = ~stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (stall && stall_cnt != {CNT_W{1'b1}})
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Table-driven bench for hazard_fwd_ctrl; expectations follow HAZARD_FWD_EN when defined.
// A second instance with a 2-bit counter exercises counter saturation.
module tb_hazard_fwd_ctrl;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic        id_reg_dst;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        flush;
    logic        ex_dest_sel;
    logic [4:0]  ex_dest;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic        stall;
    logic        pc_we;
    logic        ifid_we;
    logic [15:0] stall_cnt;
    logic        s_ex_dest_sel;
    logic [4:0]  s_ex_dest;
    logic [1:0]  s_fwd_a;
    logic [1:0]  s_fwd_b;
    logic        s_stall;
    logic        s_pc_we;
    logic        s_ifid_we;
    logic [1:0]  s_stall_cnt;

    int tests;
    int failed;
    int step;

    hazard_fwd_ctrl #(.REG_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .flush(flush), .ex_dest_sel(ex_dest_sel),
        .ex_dest(ex_dest), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall), .pc_we(pc_we),
        .ifid_we(ifid_we), .stall_cnt(stall_cnt)
    );

    hazard_fwd_ctrl #(.REG_W(5), .CNT_W(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .flush(flush), .ex_dest_sel(s_ex_dest_sel),
        .ex_dest(s_ex_dest), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .stall(s_stall),
        .pc_we(s_pc_we), .ifid_we(s_ifid_we), .stall_cnt(s_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        dst;
        logic        rw;
        logic        mr;
        logic        fl;
        logic        e_stall;
        logic [1:0]  e_fa;
        logic [1:0]  e_fb;
        logic [4:0]  e_dest;
        logic        e_sel;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

`ifdef HAZARD_FWD_EN
    localparam int PAIR_STALLS = 1;
    localparam int N_PAIRS     = 4;
`else
    localparam int PAIR_STALLS = 2;
    localparam int N_PAIRS     = 2;
`endif

    task automatic addVec(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic dst, input logic rw,
                          input logic mr, input logic fl, input logic e_stall,
                          input logic [1:0] e_fa, input logic [1:0] e_fb,
                          input logic [4:0] e_dest, input logic e_sel, input int e_cnt);
        vec_t t;
        t.v = v; t.rs = rs; t.rt = rt; t.rd = rd; t.dst = dst; t.rw = rw; t.mr = mr;
        t.fl = fl; t.e_stall = e_stall; t.e_fa = e_fa; t.e_fb = e_fb; t.e_dest = e_dest;
        t.e_sel = e_sel; t.e_cnt = 16'(e_cnt);
        vecs.push_back(t);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic dst, input logic rw,
                         input logic mr, input logic fl);
        @(negedge clk);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_reg_dst = dst;
        id_reg_write = rw; id_mem_read = mr; flush = fl;
        #1;
    endtask

    task automatic applyStimulus(input vec_t t);
        drive(t.v, t.rs, t.rt, t.rd, t.dst, t.rw, t.mr, t.fl);
    endtask

    // Producer writes r, consumer reads it; measures how long the consumer is held.
    task automatic hazardPair(input logic [4:0] r, input int exp_stalls);
        int n;
        drive(1, 5'd1, r, 5'd0, 0, 1, 1, 0);
        drive(1, r, 5'd1, 5'd21, 1, 1, 0, 0);
        n = 0;
        for (int i = 0; i < 10 && stall; i++) begin
            n++;
            @(negedge clk);
            #1;
        end
        checkOutput("stallBound", {31'd0, stall}, 32'd0);
        checkOutput("stallLen", n, exp_stalls);
        repeat (3) drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int base_cnt;
        int exp_cnt;
        tests = 0; failed = 0; step = 0;
        rst_n = 1'b0;
        id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_reg_dst = 0;
        id_reg_write = 0; id_mem_read = 0; flush = 0;

        // Destination select and drain, identical in both builds.
        addVec(1, 5'd1, 5'd4, 5'd9, 1, 1, 0, 0,  0, 2'b00, 2'b00, 5'd0, 0, 0);
        addVec(1, 5'd2, 5'd4, 5'd7, 0, 1, 0, 0,  0, 2'b00, 2'b00, 5'd9, 1, 0);
        addVec(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0,  0, 2'b00, 2'b00, 5'd4, 0, 0);
        addVec(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0,  0, 2'b00, 2'b00, 5'd0, 0, 0);
        addVec(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0,  0, 2'b00, 2'b00, 5'd0, 0, 0);
`ifdef HAZARD_FWD_EN
        addVec(1, 5'd1, 5'd2, 5'd3, 1, 1, 0, 0,  0, 2'b00, 2'b00, 5'd0, 0, 0);
        addVec(1, 5'd3, 5'd3, 5'd5, 1, 1, 0, 0,  0, 2'b00, 2'b00, 5'd3, 1, 0);
        addVec(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0,  0, 2'b10, 2'b10, 5'd5, 1, 0);
        addVec(1, 5'd1, 5'd2, 5'd3, 1, 1, 0, 0,  0, 2'b00, 2'b00, 5'd0, 0, 0);
        addVec(1, 5'd10, 5'd11, 5'd12, 1, 1, 0, 0, 0, 2'b00, 2'b00, 5'd3, 1, 0);
        addVec(1, 5'd3, 5'd3, 5'd13, 1, 1, 0, 0, 0, 2'b00, 2'b00, 5'd12, 1, 0);
        addVec(1, 5'd1, 5'd2, 5'd0, 1, 1, 0, 0,  0, 2'b01, 2'b01, 5'd13, 1, 0);
        addVec(1, 5'd0, 5'd0, 5'd14, 1, 1, 0, 0, 0, 2'b00, 2'b00, 5'd0, 1, 0);
        addVec(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0,  0, 2'b00, 2'b00, 5'd14, 1, 0);
        addVec(1, 5'd1, 5'd2, 5'd7, 1, 1, 0, 0,  0, 2'b00, 2'b00, 5'd0, 0, 0);
        addVec(1, 5'd1, 5'd2, 5'd7, 1, 1, 0, 0,  0, 2'b00, 2'b00, 5'd7, 1, 0);
        addVec(1, 5'd7, 5'd1, 5'd15, 1, 1, 0, 0, 0, 2'b00, 2'b00, 5'd7, 1, 0);
        addVec(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0,  0, 2'b10, 2'b00, 5'd15, 1, 0);
        addVec(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0,  0, 2'b00, 2'b00, 5'd0, 0, 0);
        addVec(1, 5'd1, 5'd8, 5'd0, 0, 1, 1, 0,  0, 2'b00, 2'b00, 5'd0, 0, 0);
        addVec(1, 5'd8, 5'd1, 5'd9, 1, 1, 0, 0,  1, 2'b00, 2'b00, 5'd8, 0, 0);
        addVec(1, 5'd8, 5'd1, 5'd9, 1, 1, 0, 0,  0, 2'b00, 2'b00, 5'd0, 0, 1);
        addVec(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0,  0, 2'b01, 2'b00, 5'd9, 1, 1);
        addVec(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0,  0, 2'b00, 2'b00, 5'd0, 0, 1);
        addVec(1, 5'd1, 5'd8, 5'd0, 0, 1, 1, 0,  0, 2'b00, 2'b00, 5'd0, 0, 1);
        addVec(1, 5'd8, 5'd8, 5'd9, 1, 1, 0, 1,  0, 2'b00, 2'b00, 5'd8, 0, 1);
        addVec(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0,  0, 2'b00, 2'b00, 5'd0, 0, 1);
        addVec(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0,  0, 2'b00, 2'b00, 5'd0, 0, 1);
        base_cnt = 1;
`else
        addVec(1, 5'd1, 5'd2, 5'd3, 1, 1, 0, 0,  0, 2'b00, 2'b00, 5'd0, 0, 0);
        addVec(1, 5'd3, 5'd3, 5'd5, 1, 1, 0, 0,  1, 2'b00, 2'b00, 5'd3, 1, 0);
        addVec(1, 5'd3, 5'd3, 5'd5, 1, 1, 0, 0,  1, 2'b00, 2'b00, 5'd0, 0, 1);
        addVec(1, 5'd3, 5'd3, 5'd5, 1, 1, 0, 0,  0, 2'b00, 2'b00, 5'd0, 0, 2);
        addVec(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0,  0, 2'b00, 2'b00, 5'd5, 1, 2);
        addVec(1, 5'd1, 5'd2, 5'd0, 1, 1, 0, 0,  0, 2'b00, 2'b00, 5'd0, 0, 2);
        addVec(1, 5'd0, 5'd0, 5'd14, 1, 1, 0, 0, 0, 2'b00, 2'b00, 5'd0, 1, 2);
        addVec(1, 5'd0, 5'd4, 5'd10, 1, 1, 0, 0, 0, 2'b00, 2'b00, 5'd14, 1, 2);
        addVec(1, 5'd14, 5'd1, 5'd11, 1, 1, 0, 1, 0, 2'b00, 2'b00, 5'd10, 1, 2);
        addVec(1, 5'd10, 5'd1, 5'd11, 1, 1, 0, 0, 1, 2'b00, 2'b00, 5'd0, 0, 2);
        addVec(1, 5'd10, 5'd1, 5'd11, 1, 1, 0, 0, 0, 2'b00, 2'b00, 5'd0, 0, 3);
        addVec(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0,  0, 2'b00, 2'b00, 5'd11, 1, 3);
        addVec(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0,  0, 2'b00, 2'b00, 5'd0, 0, 3);
        addVec(1, 5'd1, 5'd6, 5'd0, 0, 0, 0, 0,  0, 2'b00, 2'b00, 5'd0, 0, 3);
        addVec(1, 5'd6, 5'd6, 5'd12, 1, 0, 0, 0, 0, 2'b00, 2'b00, 5'd6, 0, 3);
        addVec(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0,  0, 2'b00, 2'b00, 5'd12, 1, 3);
        addVec(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0,  0, 2'b00, 2'b00, 5'd0, 0, 3);
        base_cnt = 3;
`endif

        // Reset state with the clock running.
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rstStall", {31'd0, stall}, 32'd0);
        checkOutput("rstPcWe", {31'd0, pc_we}, 32'd1);
        checkOutput("rstDest", {27'd0, ex_dest}, 32'd0);
        checkOutput("rstCnt", {16'd0, stall_cnt}, 32'd0);
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            step = k;
            applyStimulus(vecs[k]);
            exp_cnt = (int'(vecs[k].e_cnt) > 3) ? 3 : int'(vecs[k].e_cnt);
            checkOutput("stall", {31'd0, stall}, {31'd0, vecs[k].e_stall});
            checkOutput("pcWe", {31'd0, pc_we}, {31'd0, ~vecs[k].e_stall});
            checkOutput("ifidWe", {31'd0, ifid_we}, {31'd0, ~vecs[k].e_stall});
            checkOutput("fwdA", {30'd0, fwd_a}, {30'd0, vecs[k].e_fa});
            checkOutput("fwdB", {30'd0, fwd_b}, {30'd0, vecs[k].e_fb});
            checkOutput("exDest", {27'd0, ex_dest}, {27'd0, vecs[k].e_dest});
            checkOutput("exSel", {31'd0, ex_dest_sel}, {31'd0, vecs[k].e_sel});
            checkOutput("stallCnt", {16'd0, stall_cnt}, {16'd0, vecs[k].e_cnt});
            checkOutput("smallCnt", {30'd0, s_stall_cnt}, exp_cnt);
        end

        // Repeated hazards push the narrow counter into saturation.
        for (int p = 1; p <= N_PAIRS; p++) begin
            step = 100 + p;
            hazardPair(5'd20, PAIR_STALLS);
            exp_cnt = base_cnt + p * PAIR_STALLS;
            checkOutput("pairCnt", {16'd0, stall_cnt}, exp_cnt);
            checkOutput("pairSmallCnt", {30'd0, s_stall_cnt}, (exp_cnt > 3) ? 3 : exp_cnt);
        end

        // Asynchronous reset in the middle of a stall, between clock edges.
        step = 200;
        drive(1, 5'd1, 5'd8, 5'd0, 0, 1, 1, 0);
        drive(1, 5'd8, 5'd1, 5'd9, 1, 1, 0, 0);
        checkOutput("preRstStall", {31'd0, stall}, 32'd1);
        checkOutput("preRstDest", {27'd0, ex_dest}, 32'd8);
        rst_n = 1'b0;
        #1;
        checkOutput("midRstStall", {31'd0, stall}, 32'd0);
        checkOutput("midRstPcWe", {31'd0, pc_we}, 32'd1);
        checkOutput("midRstIfidWe", {31'd0, ifid_we}, 32'd1);
        checkOutput("midRstFwd", {28'd0, fwd_a, fwd_b}, 32'd0);
        checkOutput("midRstDest", {26'd0, ex_dest_sel, ex_dest}, 32'd0);
        checkOutput("midRstCnt", {16'd0, stall_cnt}, 32'd0);
        checkOutput("midRstSmallCnt", {30'd0, s_stall_cnt}, 32'd0);
        #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
